// File: rtl/seg_scan_reader.sv
// seg_scan_reader: reads a time-multiplexed 7-segment drive bus back into hex nibbles.
// A shared segment bus (bit0=a .. bit6=g) plus one-hot digit enables is sampled once,
// and each digit is checked for stability before it is decoded into its own nibble slot.
// When every digit has been captured at least once, a one-cycle frame_done pulse is
// issued. Captures of illegal non-blank patterns raise a one-cycle err pulse.
//
// Optional build macro: SEG_ACTIVE_LOW_EN
//   defined   -> seg and an are inverted ahead of the input register (common-anode boards)
//   undefined -> seg and an are used as-is (active-high)
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,    // 1..8
    parameter int STABLE_CYCLES = 4     // >= 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err
);

    // The run counter only has to reach STABLE_CYCLES-1, so size it for that.
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]         CAP_AT   = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [6:0]              w_seg_in;
    logic [NUM_DIGITS-1:0]   w_an_in;

    logic [6:0]              r_seg_q;
    logic [NUM_DIGITS-1:0]   r_an_q;
    logic [6:0]              r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_an_prev;

    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_next;
    logic [CW-1:0]           w_run;

    logic [NUM_DIGITS-1:0]   r_seen;
    logic [NUM_DIGITS-1:0]   w_seen_or;

    logic                    r_frame_done;
    logic                    r_err;

    logic                    w_one_hot;
    logic                    w_same;
    logic                    w_capture;
    logic                    w_frame_hit;
    logic                    w_err_hit;

    logic [3:0]              w_nib;
    logic                    w_legal;
    logic                    w_blank;

`ifdef SEG_ACTIVE_LOW_EN
    // Common-anode boards drive both buses low-true; flip them so everything
    // downstream sees the same active-high view as the default build.
    assign w_seg_in = ~seg;
    assign w_an_in  = ~an;
`else
    assign w_seg_in = seg;
    assign w_an_in  = an;
`endif

    // Single input register stage; every decision below uses these sampled values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_q <= '0;
            r_an_q  <= '0;
        end else begin
            r_seg_q <= w_seg_in;
            r_an_q  <= w_an_in;
        end
    end

    // Previous-cycle copy of the sampled inputs, used to detect any change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_prev <= '0;
            r_an_prev  <= '0;
        end else begin
            r_seg_prev <= r_seg_q;
            r_an_prev  <= r_an_q;
        end
    end

    assign w_one_hot = (r_an_q != '0) && ((r_an_q & (r_an_q - AN_ONE)) == '0);
    assign w_same    = (r_seg_q == r_seg_prev) && (r_an_q == r_an_prev);

    // State and run-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and capture decision. w_run counts identical samples beyond the
    // first one in the current window, so the first sample of a fresh window
    // (coming from IDLE, or after any change) is run 0 and can already capture
    // when a single stable sample is enough.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_run        = '0;
        w_capture    = 1'b0;
        if (!w_one_hot) begin
            // No digit or several digits enabled: nothing meaningful to read.
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else if ((r_state == S_HOLD) && w_same) begin
            // Already captured this pattern; wait for the bus to move on.
            w_state_next = S_HOLD;
            w_cnt_next   = '0;
        end else begin
            if ((r_state == S_SETTLE) && w_same) begin
                w_run = r_cnt + CNT_ONE;
            end else begin
                w_run = '0;
            end
            if (w_run == CAP_AT) begin
                w_capture    = 1'b1;
                w_state_next = S_HOLD;
                w_cnt_next   = '0;
            end else begin
                w_state_next = S_SETTLE;
                w_cnt_next   = w_run;
            end
        end
    end

    // Segment pattern to nibble decode; 0x00 is blank, anything unlisted is illegal.
    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
        case (r_seg_q)
            7'h3F:   w_nib = 4'h0;
            7'h06:   w_nib = 4'h1;
            7'h5B:   w_nib = 4'h2;
            7'h4F:   w_nib = 4'h3;
            7'h66:   w_nib = 4'h4;
            7'h6D:   w_nib = 4'h5;
            7'h7D:   w_nib = 4'h6;
            7'h07:   w_nib = 4'h7;
            7'h7F:   w_nib = 4'h8;
            7'h6F:   w_nib = 4'h9;
            7'h77:   w_nib = 4'hA;
            7'h7C:   w_nib = 4'hB;
            7'h39:   w_nib = 4'hC;
            7'h5E:   w_nib = 4'hD;
            7'h79:   w_nib = 4'hE;
            7'h71:   w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_blank     = (r_seg_q == 7'h00);
    assign w_seen_or   = r_seen | r_an_q;
    assign w_frame_hit = w_capture && (w_seen_or == ALL_SEEN);
    assign w_err_hit   = w_capture && !w_legal && !w_blank;

    // Frame tracking: any capture marks its digit as seen; completing the set
    // pulses frame_done and starts a fresh frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen <= '0;
        end else if (w_capture) begin
            r_seen <= w_frame_hit ? '0 : w_seen_or;
        end
    end

    // One-cycle status pulses, re-evaluated every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_frame_hit;
            r_err        <= w_err_hit;
        end
    end

    assign frame_done = r_frame_done;
    assign err        = r_err;

    // Per-digit storage. Only a legal pattern overwrites the nibble; blank and
    // illegal captures just drop the valid flag so the last good value survives.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_nib;
            logic       r_vld;

            // Update this digit when a capture targets its enable bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_nib <= 4'h0;
                    r_vld <= 1'b0;
                end else if (w_capture && r_an_q[gi]) begin
                    if (w_legal) begin
                        r_nib <= w_nib;
                    end
                    r_vld <= w_legal;
                end
            end

            assign digits[4*gi +: 4] = r_nib;
            assign digit_valid[gi]   = r_vld;
        end
    endgenerate

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader (NUM_DIGITS=4, STABLE_CYCLES=4, active-high build).
// Hand-written sequences cover reset, exact capture latency and reset mid-window;
// a vector table covers scanning, illegal/blank patterns, toggling, multi-hot and the
// full decode table.
module tb_seg_scan_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg   = 7'h00;
    logic [ND-1:0]     an    = '0;
    logic [4*ND-1:0]   digits;
    logic [ND-1:0]     digit_valid;
    logic              frame_done;
    logic              err;

    seg_scan_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int err_seen  = 0;
    int frm_seen  = 0;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [7:0]  cyc;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [1:0]  n_err;
        logic [1:0]  n_frm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] a, input logic [6:0] s, input int c,
                                input logic [15:0] d, input logic [3:0] v,
                                input int ne, input int nf);
        vec_t r;
        r.an    = a;
        r.seg   = s;
        r.cyc   = 8'(c);
        r.dig   = d;
        r.val   = v;
        r.n_err = 2'(ne);
        r.n_frm = 2'(nf);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after each edge and count pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (err === 1'b1)        err_seen++;
            if (frame_done === 1'b1) frm_seen++;
        end
    endtask

    logic [6:0] seg_tab [16];
    logic [3:0] nib;
    int e0, f0;

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // Reset with inputs idle.
        tick(3);
        rst_n = 1'b1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid",  32'(digit_valid), 32'h0);
        check("rst_frame",  32'(frame_done), 32'h0);
        check("rst_err",    32'(err), 32'h0);
        err_seen = 0;
        frm_seen = 0;
        tick(10);
        check("idle_err_pulses",   32'(err_seen), 32'h0);
        check("idle_frame_pulses", 32'(frm_seen), 32'h0);

        // Capture latency: nothing through edge 4, capture on edge 5.
        an  = 4'b0001;
        seg = 7'h5B;
        tick(4);
        check("lat_edge4_valid",  32'(digit_valid), 32'h0);
        check("lat_edge4_digits", 32'(digits), 32'h0);
        tick(1);
        check("lat_edge5_digits", 32'(digits), 32'h0002);
        check("lat_edge5_valid",  32'(digit_valid), 32'h1);
        check("lat_err_pulses",   32'(err_seen), 32'h0);

        // Vector table: scan, illegal, toggling, multi-hot, decode sweep, blank, illegal.
        vecs.push_back(mk(4'b0001, 7'h06, 8, 16'h0001, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0010, 7'h4F, 8, 16'h0031, 4'b0011, 0, 0));
        vecs.push_back(mk(4'b0100, 7'h77, 8, 16'h0A31, 4'b0111, 0, 0));
        vecs.push_back(mk(4'b1000, 7'h71, 8, 16'hFA31, 4'b1111, 0, 1));
        vecs.push_back(mk(4'b0010, 7'h7E, 8, 16'hFA31, 4'b1101, 1, 0));
        vecs.push_back(mk(4'b0100, 7'h3F, 2, 16'hFA31, 4'b1101, 0, 0));
        vecs.push_back(mk(4'b0100, 7'h06, 2, 16'hFA31, 4'b1101, 0, 0));
        vecs.push_back(mk(4'b0100, 7'h3F, 2, 16'hFA31, 4'b1101, 0, 0));
        vecs.push_back(mk(4'b0100, 7'h06, 2, 16'hFA31, 4'b1101, 0, 0));
        vecs.push_back(mk(4'b0011, 7'h3F, 8, 16'hFA31, 4'b1101, 0, 0));
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            vecs.push_back(mk(4'b1000, seg_tab[i], 6, {nib, 12'hA31}, 4'b1101, 0, 0));
        end
        vecs.push_back(mk(4'b1000, 7'h00, 6, 16'hFA31, 4'b0101, 0, 0));
        vecs.push_back(mk(4'b0001, 7'h01, 6, 16'hFA31, 4'b0100, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            an  = vecs[i].an;
            seg = vecs[i].seg;
            e0  = err_seen;
            f0  = frm_seen;
            tick(int'(vecs[i].cyc));
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].dig));
            check($sformatf("v%0d_valid", i),  32'(digit_valid), 32'(vecs[i].val));
            check($sformatf("v%0d_err", i),    32'(err_seen - e0), 32'(vecs[i].n_err));
            check($sformatf("v%0d_frame", i),  32'(frm_seen - f0), 32'(vecs[i].n_frm));
        end

        // Reset two cycles into a stable window; the window must restart afterwards.
        an  = 4'b0001;
        seg = 7'h6D;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_valid",  32'(digit_valid), 32'h0);
        check("midrst_err",    32'(err), 32'h0);
        check("midrst_frame",  32'(frame_done), 32'h0);
        tick(4);
        check("midrst_edge4_valid", 32'(digit_valid), 32'h0);
        tick(1);
        check("midrst_edge5_digits", 32'(digits), 32'h0005);
        check("midrst_edge5_valid",  32'(digit_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Receive-side counterpart of the hex-to-7-segment display path.
- Monitors a time-multiplexed 7-segment drive bus: a shared segment bus plus one-hot digit enables.
- Reconstructs the hex nibble shown on each digit and reports when a full display frame has been captured.
- Used for display loopback self-test and for reading an external multiplexed display back into the datapath.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, width of the digit-enable bus; legal range 1..8.
- STABLE_CYCLES, 4: consecutive identical registered samples required before a capture; minimum 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg  input  7  segment bus; bit0=a .. bit6=g; active-high in default build.
- an  input  NUM_DIGITS  digit enables; one-hot, active-high in default build.
- digits  output  4*NUM_DIGITS  captured nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set when digit i last captured a legal hex pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- err  output  1  one-cycle pulse on capture of an illegal, non-blank pattern.

Behaviour:
- Reset (rst_n low at a clk edge) clears all of the following:
  - digits, digit_valid, frame_done, err to 0.
  - Input sample registers, previous-sample registers, stability counter and seen-mask to 0.
  - FSM to IDLE.
  - Any partially counted stability window is discarded.
- Input stage: seg and an registered once (seg_q, an_q); all decisions use registered values.
- Decode table (seg value -> nibble), 16 entries:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7.
  - 0x7F->8, 0x6F->9, 0x77->A, 0x7C->B, 0x39->C, 0x5E->D, 0x79->E, 0x71->F.
  - seg_q==0x00 is blank.
  - Any other value is illegal.
- FSM, three states:
  - IDLE: an_q zero or not one-hot. Counter held at 0, no capture. Moves to SETTLE when an_q becomes one-hot.
  - SETTLE: counter increments each cycle where seg_q and an_q equal their previous-cycle values. Any change restarts the count at 0. When the count reaches STABLE_CYCLES-1, capture occurs and the FSM moves to HOLD. With STABLE_CYCLES=1, capture occurs on the first cycle in SETTLE.
  - HOLD: no further capture while inputs are unchanged. Any change in seg_q or an_q returns to SETTLE, or to IDLE if an_q is no longer one-hot.
- Latency: with inputs steady, outputs update at the rising edge STABLE_CYCLES+1 cycles after the pins settle (1 input register + STABLE_CYCLES count).
- Capture for digit i (the set bit of an_q):
  - Legal pattern: digits[i] <= nibble; digit_valid[i] <= 1.
  - Blank: digit_valid[i] <= 0; digits[i] retained; no err.
  - Illegal: digit_valid[i] <= 0; digits[i] retained; err pulses on the same edge.
- Frame completion:
  - seen[i] is set on any capture of digit i.
  - When the capture makes seen all-ones, frame_done pulses on that edge and seen clears to 0.
  - Recapturing an already-seen digit does not advance the frame.
- Multi-hot an: treated as IDLE; no capture, no err.
- At most one capture per cycle, so frame_done and err may pulse together but never repeat in consecutive cycles without a new stable window.

Optional Feature:
- Macro SEG_ACTIVE_LOW_EN.
- Defined: seg and an are inverted before the input register, which supports common-anode boards with active-low drive. All internal behaviour, the decode table and the outputs are unchanged.
- Undefined: inputs are used as-is (active-high).

Test Plan:
1. Reset release, inputs at 0 -> all outputs 0; after 10 cycles still no err and no frame_done.
2. STABLE_CYCLES=4; an=0001, seg=0x5B held 5 cycles -> digits[3:0]=2 and digit_valid[0]=1 at edge 5 after settle; no err.
3. Scan an=0001/0010/0100/1000 with 0x06, 0x4F, 0x77, 0x71, 8 cycles each -> digits=0xFA31, digit_valid=1111, a single frame_done on the 4th capture.
4. an=0010, seg=0x7E (illegal) held 8 cycles -> err pulses exactly once; digit_valid[1]=0; digits[7:4] unchanged.
5. seg toggles 0x3F/0x06 every 2 cycles with STABLE_CYCLES=4 -> no capture; then an=0011 held 8 cycles -> no capture, no err.
6. rst_n low for 1 cycle, 2 cycles into a stable window -> outputs cleared; capture occurs only STABLE_CYCLES+1 cycles after rst_n returns high.
